// File: rtl/dsp_addsub_pipe.sv
// Purpose : pipelined two's-complement adder/subtractor, one SEG_W-bit segment per stage,
//           carry registered between stages; carry/borrow, zero and signed-overflow flags.
// Latency : STAGES = WIDTH/SEG_W cycles; one operation per cycle sustained.
// Backpressure: whole pipeline holds while out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand beat handshake; op_sub, a, b sampled on transfer
//   out_valid/out_ready   result beat handshake
//   result                sum/difference (low WIDTH bits)
//   carry_out             carry from MSB; on subtract 1 = no borrow (A >= B unsigned)
//   zero                  unsaturated result == 0
//   overflow              signed overflow of the operation
// Optional build macro: DSP_ADDSUB_SAT_EN -- saturate result on signed overflow
//   (flags still describe the unsaturated operation). Undefined: result wraps.
// WIDTH must be a multiple of SEG_W (16..128).

module dsp_addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             overflow
);

   localparam int STAGES = WIDTH / SEG_W;
   localparam int LAST   = STAGES - 1;
   // Intermediate register banks exist only between stages; keep at least one
   // entry so the declarations stay legal for a single-stage build.
   localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;

   // Per-stage inputs (operands, partial sum of completed lower segments, carry-in, valid)
   logic [WIDTH-1:0] w_ia [STAGES];
   logic [WIDTH-1:0] w_ib [STAGES];
   logic [WIDTH-1:0] w_is [STAGES];
   logic             w_ic [STAGES];
   logic             w_iv [STAGES];
   // Per-stage segment adder output and updated partial sum
   logic [SEG_W:0]   w_seg [STAGES];
   logic [WIDTH-1:0] w_sn  [STAGES];

   // Inter-stage registers
   logic [WIDTH-1:0] r_a [MID];
   logic [WIDTH-1:0] r_b [MID];
   logic [WIDTH-1:0] r_s [MID];
   logic             r_c [MID];
   logic             r_v [MID];

   // Output stage registers
   logic             r_ovld;
   logic [WIDTH-1:0] r_res;
   logic             r_cy;
   logic             r_zero;
   logic             r_ovf;

   logic             w_adv;
   logic             w_sa;
   logic             w_sb;
   logic             w_sr;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   // No bubble squeezing: every stage advances together whenever the output
   // register is empty or being drained this cycle.
   assign w_adv    = !r_ovld || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            // Subtract is A + ~B + 1: invert B here and feed op_sub as carry-in.
            w_ia[k] = a;
            w_ib[k] = op_sub ? ~b : b;
            w_is[k] = '0;
            w_ic[k] = op_sub;
            w_iv[k] = in_valid;
         end else begin
            w_ia[k] = r_a[(k > 0) ? k - 1 : 0];
            w_ib[k] = r_b[(k > 0) ? k - 1 : 0];
            w_is[k] = r_s[(k > 0) ? k - 1 : 0];
            w_ic[k] = r_c[(k > 0) ? k - 1 : 0];
            w_iv[k] = r_v[(k > 0) ? k - 1 : 0];
         end
         w_seg[k] = {1'b0, w_ia[k][k*SEG_W +: SEG_W]}
                  + {1'b0, w_ib[k][k*SEG_W +: SEG_W]}
                  + {{SEG_W{1'b0}}, w_ic[k]};
         // Segments above k are still zero in the partial sum, so OR-in is exact.
         w_sn[k]  = w_is[k] | (WIDTH'(w_seg[k][SEG_W-1:0]) << (k * SEG_W));
      end
   end

   // Signed overflow: operands (with B already inverted) agree in sign but result does not.
   assign w_sa  = w_ia[LAST][WIDTH-1];
   assign w_sb  = w_ib[LAST][WIDTH-1];
   assign w_sr  = w_sn[LAST][WIDTH-1];
   assign w_ovf = (w_sa == w_sb) && (w_sr != w_sa);

`ifdef DSP_ADDSUB_SAT_EN
   // Positive overflow (A non-negative) clamps to max, negative to min.
   assign w_res = !w_ovf ? w_sn[LAST] :
                  w_sa   ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_res = w_sn[LAST];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MID; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
      end else if (w_adv) begin
         for (int k = 0; k < LAST; k++) begin
            r_a[k] <= w_ia[k];
            r_b[k] <= w_ib[k];
            r_s[k] <= w_sn[k];
            r_c[k] <= w_seg[k][SEG_W];
            r_v[k] <= w_iv[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovld <= 1'b0;
         r_res  <= '0;
         r_cy   <= 1'b0;
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_ovld <= w_iv[LAST];
         r_res  <= w_res;
         r_cy   <= w_seg[LAST][SEG_W];
         r_zero <= ~|w_sn[LAST];
         r_ovf  <= w_ovf;
      end
   end

   assign out_valid = r_ovld;
   assign result    = r_res;
   assign carry_out = r_cy;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Purpose : directed bench for dsp_addsub_pipe at WIDTH=32 (two stages).
// Latency : every beat accepted with out_ready held high must appear two cycles later.
// Backpressure: exercises a five-cycle out_ready stall and an asynchronous reset mid-flight.

module tb_dsp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op_sub = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        carry_out;
   logic        zero;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        z;
      logic        o;
      int          acc;
      logic        lat;
   } exp_t;

   exp_t q[$];

   dsp_addsub_pipe #(.WIDTH(32), .SEG_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference for streamed beats: plain 33-bit arithmetic on the whole word.
   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
      exp_t        e;
      logic [31:0] bb;
      logic [32:0] s;
      bb    = isub ? ~ib : ib;
      s     = {1'b0, ia} + {1'b0, bb} + 33'(isub);
      e.c   = s[32];
      e.z   = (s[31:0] == 32'h0);
      e.o   = (ia[31] == bb[31]) && (s[31] != ia[31]);
      e.res = s[31:0];
`ifdef DSP_ADDSUB_SAT_EN
      if (e.o) e.res = ia[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      e.acc = 0;
      e.lat = 1'b1;
      return e;
   endfunction

   // One clock cycle: drive after the rising edge, book-keep at the falling edge
   // for the transfers that the next rising edge will perform.
   task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic ordy, input exp_t e, output logic acc);
      exp_t x;
      @(posedge clk);
      cyc++;
      #1;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      op_sub    = isub;
      out_ready = ordy;
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check_val("spurious_beat", 64'(out_valid), 64'(0));
         end else begin
            x = q.pop_front();
            check_val("result",    64'(result),    64'(x.res));
            check_val("carry_out", 64'(carry_out), 64'(x.c));
            check_val("zero",      64'(zero),      64'(x.z));
            check_val("overflow",  64'(overflow),  64'(x.o));
            if (x.lat) check_val("latency", 64'(cyc - x.acc), 64'(2));
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      exp_t e;
      logic acc;
      e = model(32'h0, 32'h0, 1'b0);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e, acc);
   endtask

   // Single directed beat with hand-computed expectations, then drain.
   task automatic dir(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                      input logic [31:0] eres, input logic ec, input logic ez, input logic eo);
      exp_t e;
      logic acc;
      e.res = eres; e.c = ec; e.z = ez; e.o = eo; e.acc = 0; e.lat = 1'b1;
      drive(1'b1, ia, ib, isub, 1'b1, e, acc);
      check_val("dir_accept", 64'(acc), 64'(1));
      idle(2);
      check_val("dir_drained", 64'(q.size()), 64'(0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        e;
      exp_t        held;
      logic        acc;
      logic [31:0] sa, sb;
      int          j;

      // Reset
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_out_valid", 64'(out_valid), 64'(0));
      check_val("rst_result",    64'(result),    64'(0));
      check_val("rst_carry",     64'(carry_out), 64'(0));
      check_val("rst_zero",      64'(zero),      64'(0));
      check_val("rst_overflow",  64'(overflow),  64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'(1));

      // Directed vectors
      dir(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
      dir(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      dir(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      dir(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
`ifdef DSP_ADDSUB_SAT_EN
      dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      dir(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
      dir(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
`else
      dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      dir(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
      dir(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
`endif

      // Back-to-back stream of 8 beats, out_ready held high
      for (int i = 0; i < 8; i++) begin
         sa = 32'h1111_1111 * i + 32'h0000_FFFF;
         sb = 32'h0001_0001 << i;
         drive(1'b1, sa, sb, i[0], 1'b1, model(sa, sb, i[0]), acc);
         check_val("stream_accept",   64'(acc),      64'(1));
         check_val("stream_in_ready", 64'(in_ready), 64'(1));
      end
      idle(3);
      check_val("stream_drained", 64'(q.size()), 64'(0));

      // Five-cycle stall mid-stream; beats retried until accepted
      j = 0;
      held = model(32'h0, 32'h0, 1'b0);
      for (int n = 0; n < 40 && j < 10; n++) begin
         sa = 32'h0F0F_0000 + 32'(j) * 32'h0001_0003;
         sb = 32'h0000_FFFF - 32'(j);
         e  = model(sa, sb, j[0]);
         e.lat = 1'b0;
         drive(1'b1, sa, sb, j[0], !(n >= 3 && n < 8), e, acc);
         if (acc) j++;
         if (n >= 3 && n < 8) begin
            check_val("stall_out_valid", 64'(out_valid), 64'(1));
            check_val("stall_in_ready",  64'(in_ready),  64'(0));
            if (n == 3) begin
               held.res = result; held.c = carry_out; held.z = zero; held.o = overflow;
            end else begin
               check_val("stall_result",   64'(result),    64'(held.res));
               check_val("stall_carry",    64'(carry_out), 64'(held.c));
               check_val("stall_zero",     64'(zero),      64'(held.z));
               check_val("stall_overflow", 64'(overflow),  64'(held.o));
            end
         end
      end
      check_val("stall_all_sent", 64'(j), 64'(10));
      for (int n = 0; n < 10 && q.size() != 0; n++) idle(1);
      check_val("stall_drained", 64'(q.size()), 64'(0));

      // Asynchronous reset with two beats in flight
      e = model(32'h0000_0005, 32'h0000_0003, 1'b0);
      drive(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, e, acc);
      e = model(32'h0000_0009, 32'h0000_0004, 1'b1);
      drive(1'b1, 32'h0000_0009, 32'h0000_0004, 1'b1, 1'b0, e, acc);
      @(posedge clk);
      #1 in_valid = 1'b0;
      #1;
      check_val("inflight_out_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      check_val("async_rst_out_valid", 64'(out_valid), 64'(0));
      check_val("async_rst_result",    64'(result),    64'(0));
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         idle(1);
         check_val("no_stale_beat", 64'(out_valid), 64'(0));
      end
      dir(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dsp_addsub_pipe.md
Name: dsp_addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the sail-core datapath; successor to the fixed 32-bit DSP subtractor.
- Operand width is split into SEG_W-bit segments, one segment per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides; full back-pressure; throughput one operation per cycle.
- Produces carry/borrow, zero and signed-overflow flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W, range 16..128.
- SEG_W, 16, segment width per stage (matches DSP adder slice width).
- STAGES, WIDTH/SEG_W (derived, not overridable), pipeline depth = latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled with operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  sum/difference, low WIDTH bits.
- carry_out  out  1  carry from MSB; for subtract, 1 = no borrow (A >= B unsigned).
- zero  out  1  result == 0.
- overflow  out  1  signed overflow of the operation.

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, result, carry_out, zero and overflow clear to 0; in_ready = 1 once reset is released. In-flight operations are discarded with no output beat.
- Accept: a beat transfers when in_valid && in_ready. Transfer: out_valid && out_ready.
- Subtract: A + ~B + 1; the inverted B and carry-in = op_sub are applied at stage 0.
- Stage k (0..STAGES-1) adds segment k of A and B' with the carry registered by stage k-1 (stage 0 carry-in = op_sub). Higher segments travel delay-matched through earlier stages; completed lower segments travel through later stages.
- Latency: a beat accepted at the edge ending cycle 0 appears with out_valid = 1 in cycle STAGES. STAGES = 2 for WIDTH = 32.
- Flags are registered alongside the last stage:
  - carry_out = carry from the top segment.
  - overflow = (sA == sB') && (sR != sA), using MSBs.
  - zero = NOR of all result bits.
- Stall: whole pipeline holds when out_valid && !out_ready. in_ready = !out_valid || out_ready, so it is combinational from out_ready. No bubble squeezing is required.
- Simultaneous accept and transfer in the same cycle: both occur; full throughput is held.
- Outputs hold stable while out_valid && !out_ready. Result contents are don't-care while out_valid = 0, but must not be X after reset.
- Wrap-around: result is modulo 2^WIDTH. Flags report wrap; result is not altered (see optional feature).

Optional Feature:
- Macro DSP_ADDSUB_SAT_EN.
- When defined: on signed overflow, result saturates to 0x7FF..F (positive overflow, A MSB = 0) or 0x800..0 (negative overflow). overflow, carry_out and zero still reflect the unsaturated operation.
- When not defined: the result wraps modulo 2^WIDTH and there is no saturation logic. Ports are identical in both builds.

Test Plan:
- WIDTH=32, a=0x0001_0000, b=0x0000_0001, op_sub=1 -> after 2 cycles result=0x0000_FFFF, carry_out=1, zero=0, overflow=0 (exercises cross-segment borrow).
- a=0x0000_FFFF, b=0x0000_0001, op_sub=0 -> result=0x0001_0000, carry_out=0 (inter-stage carry). Then a=b=0x1234_5678, op_sub=1 -> result=0, zero=1, carry_out=1.
- a=0x7FFF_FFFF, b=1, op_sub=0 -> overflow=1; result=0x8000_0000 without macro, 0x7FFF_FFFF with DSP_ADDSUB_SAT_EN. Also a=0x8000_0000, b=1, op_sub=1 -> overflow=1; result=0x7FFF_FFFF without macro, 0x8000_0000 with it.
- Back-to-back stream of 8 beats with out_ready=1 -> 8 results in order on consecutive cycles starting at cycle 2; in_ready held at 1 throughout.
- out_ready=0 for 5 cycles mid-stream -> pipeline fills, in_ready=0, result/flags stable; after out_ready=1 no beat is lost or duplicated; order is preserved.
- Assert rst_n=0 with 2 beats in flight -> out_valid drops to 0 asynchronously; after release no stale beat emerges; the next accepted beat has latency 2.
